soc_bus_fabric: RTL and testbench
=================================

// Module: soc_bus_fabric
// PURPOSE
//  Parametrised address decoder / read-return mux between the ARM9-compatible core data port and N peripherals.
//  Decodes the top address nibble against a per-slave tag and drives one-hot chip enables.
//  Registers the slave select so read data returns one cycle after the access.
//  Flags unmapped accesses with a one-cycle abort and captures the faulting address and a saturating error count.
// PARAMETERS
//  N_SLV     4                          number of slave ports (1..8)
//  SLV_TAGS  {4'hd,4'he,4'h0,4'h4}      N_SLV*4 bits; slave i owns addr[31:28]==SLV_TAGS[4i+3:4i]
//  DEF_SLV   0                          slave selected out of reset
//  ERR_W     8                          width of error counter
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          asynchronous active-low reset
//  ram_cen    in   1          CPU data access strobe
//  ram_wen    in   1          1=write, 0=read (valid with ram_cen)
//  ram_addr   in   32         CPU byte address
//  ram_flag   in   4          byte enables
//  ram_wdata  in   32         write data
//  ram_rdata  out  32         read data returned to CPU
//  ram_abort  out  1          data abort to CPU
//  slv_ce     out  N_SLV      one-hot slave chip enables (combinational)
//  slv_we     out  1          write strobe to slaves (=ram_cen&ram_wen&hit)
//  slv_addr   out  32         address pass-through
//  slv_flag   out  4          byte enables pass-through
//  slv_wdata  out  32         write data pass-through
//  slv_rdata  in   N_SLV*32   slave read data, slave i at [32i+31:32i]
//  err_clr    in   1          clears err_cnt and err_vld
//  err_vld    out  1          sticky: an unmapped access has occurred
//  err_addr   out  32         address of first unmapped access since clear
//  err_cnt    out  ERR_W      saturating count of unmapped accesses
// BEHAVIOUR
//  - Decode: hit[i] = ram_cen & (ram_addr[31:28]==tag i). Duplicate tags: lowest index wins; slv_ce one-hot or zero.
//  - slv_ce/slv_we combinational, same cycle as ram_cen; slaves see address and data in that cycle.
//  - sel_q (N_SLV bits) and unmap_q load on every ram_cen cycle (read or write), hold otherwise.
//  - ram_rdata = slv_rdata of slave in sel_q; 32'h0 when unmap_q=1. Read latency is 1 cycle after ram_cen.
//  - Reset: sel_q=one-hot DEF_SLV, unmap_q=0, ram_abort=0, err_vld=0, err_addr=0, err_cnt=0.
//  - Unmapped: ram_cen with no hit -> no slv_ce, slv_we=0; ram_abort=1 for exactly the next cycle.
//    Back-to-back unmapped accesses: abort stays high each following cycle.
//  - Error capture: on unmapped access with err_vld=0, err_addr<=ram_addr and err_vld<=1; later ones keep err_addr.
//    err_cnt increments per unmapped access and saturates at all-ones.
//  - err_clr with a simultaneous unmapped access: clear wins over the old state, then the new access is captured:
//    err_vld=1, err_addr=new address, err_cnt=1.
//  - Reset mid-access: all registers return to reset values at once; no abort is issued for the cut access.
// TESTING
//  1 Read tag 4'h4 addr 32'h4000_0010, slave0 data 32'hA5A5_0001 -> slv_ce=4'b0001 that cycle; ram_rdata=32'hA5A5_0001 next cycle.
//  2 Write 32'he000_0004 data 32'h41, flag 4'h1 -> slv_ce=4'b0100, slv_we=1; no abort; sel_q=4'b0100 afterwards.
//  3 Read 32'h8000_0000 (unmapped) -> slv_ce=0; next cycle ram_abort=1, ram_rdata=0, err_addr=32'h8000_0000, err_cnt=1.
//  4 300 consecutive unmapped accesses, ERR_W=8 -> err_cnt=8'hFF; err_addr still holds the first address; abort high throughout.
//  5 err_clr together with unmapped access to 32'h9000_0004 -> err_cnt=1, err_addr=32'h9000_0004, err_vld=1.
//  6 Assert rst_n=0 mid-burst, then release -> sel_q=one-hot DEF_SLV, err_*=0; the first read after reset returns the correct slave.

Source files
------------

// File: rtl/soc_bus_fabric_if.sv
// CPU data-port and slave-side bus bundles for the SoC address-decode fabric.
interface soc_cpu_if;
   logic        ram_cen;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [3:0]  ram_flag;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_abort;

   modport master (output ram_cen, ram_wen, ram_addr, ram_flag, ram_wdata,
                   input  ram_rdata, ram_abort);
   modport slave  (input  ram_cen, ram_wen, ram_addr, ram_flag, ram_wdata,
                   output ram_rdata, ram_abort);
endinterface

interface soc_slv_if #(parameter int unsigned N_SLV = 4);
   logic [N_SLV-1:0]    slv_ce;
   logic                slv_we;
   logic [31:0]         slv_addr;
   logic [3:0]          slv_flag;
   logic [31:0]         slv_wdata;
   logic [N_SLV*32-1:0] slv_rdata;

   modport master (output slv_ce, slv_we, slv_addr, slv_flag, slv_wdata,
                   input  slv_rdata);
   modport slave  (input  slv_ce, slv_we, slv_addr, slv_flag, slv_wdata,
                   output slv_rdata);
endinterface

// File: rtl/soc_bus_fabric.sv
// Address decoder / read-return mux between the core data port and N_SLV peripherals,
// with one-cycle abort on unmapped accesses and error capture.
module soc_bus_fabric_tag_cmp #(
   parameter logic [3:0] TAG = 4'h0
) (
   input  logic [3:0] nib,
   output logic       match
);
   assign match = (nib == TAG);
endmodule

module soc_bus_fabric #(
   parameter int unsigned          N_SLV    = 4,
   parameter logic [N_SLV*4-1:0]   SLV_TAGS = {4'hd, 4'he, 4'h0, 4'h4},
   parameter int unsigned          DEF_SLV  = 0,
   parameter int unsigned          ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   soc_cpu_if.slave         cpu,
   soc_slv_if.master        slv,
   input  logic             err_clr,
   output logic             err_vld,
   output logic [31:0]      err_addr,
   output logic [ERR_W-1:0] err_cnt
);
   localparam logic [N_SLV-1:0] DEF_OH = N_SLV'(1) << DEF_SLV;

   logic [N_SLV-1:0] match;
   logic [N_SLV-1:0] hit;
   logic             miss;
   logic [N_SLV-1:0] sel_q;
   logic             unmap_q;
   logic             abort_q;
   logic             vld_eff;
   logic [ERR_W-1:0] cnt_eff;
   logic [31:0]      rdata_mux;

   genvar gi;
   generate
      for (gi = 0; gi < N_SLV; gi++) begin : g_tag
         soc_bus_fabric_tag_cmp #(.TAG(SLV_TAGS[4*gi +: 4])) u_cmp (
            .nib   (cpu.ram_addr[31:28]),
            .match (match[gi])
         );
      end
   endgenerate

   // Duplicate tags resolve to the lowest index so slv_ce is never multi-hot.
   always_comb begin
      logic found;
      hit   = '0;
      found = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (cpu.ram_cen && match[i] && !found) begin
            hit[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign miss = cpu.ram_cen & ~(|hit);

   assign slv.slv_ce    = hit;
   assign slv.slv_we    = cpu.ram_cen & cpu.ram_wen & (|hit);
   assign slv.slv_addr  = cpu.ram_addr;
   assign slv.slv_flag  = cpu.ram_flag;
   assign slv.slv_wdata = cpu.ram_wdata;

   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < N_SLV; i++)
         if (sel_q[i]) rdata_mux = rdata_mux | slv.slv_rdata[32*i +: 32];
   end

   assign cpu.ram_rdata = unmap_q ? 32'h0 : rdata_mux;
   assign cpu.ram_abort = abort_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= DEF_OH;
         unmap_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= miss;
         if (cpu.ram_cen) begin
            sel_q   <= hit;
            unmap_q <= miss;
         end
      end
   end

   // A clear in the same cycle as a fault is applied first, so the fault is captured fresh.
   assign vld_eff = err_vld & ~err_clr;
   assign cnt_eff = err_clr ? '0 : err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_vld  <= 1'b0;
         err_addr <= 32'h0;
         err_cnt  <= '0;
      end else begin
         if (err_clr) begin
            err_vld <= 1'b0;
            err_cnt <= '0;
         end
         if (miss) begin
            if (!vld_eff) begin
               err_addr <= cpu.ram_addr;
               err_vld  <= 1'b1;
            end
            if (!(&cnt_eff)) err_cnt <= cnt_eff + ERR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: decode, read return, abort and error capture.
module tb_soc_bus_fabric;
   logic        clk;
   logic        rst_n;
   logic        err_clr;
   logic        err_vld;
   logic [31:0] err_addr;
   logic [7:0]  err_cnt;

   int n_chk;
   int n_fail;
   int abort_lo;

   soc_cpu_if          cpu ();
   soc_slv_if #(.N_SLV(4)) slv ();

   soc_bus_fabric #(.N_SLV(4), .SLV_TAGS({4'hd, 4'he, 4'h0, 4'h4}), .DEF_SLV(0), .ERR_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu      (cpu.slave),
      .slv      (slv.master),
      .err_clr  (err_clr),
      .err_vld  (err_vld),
      .err_addr (err_addr),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic cen, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] flag, input logic clr);
      @(posedge clk); #1;
      cpu.ram_cen   = cen;
      cpu.ram_wen   = wen;
      cpu.ram_addr  = addr;
      cpu.ram_wdata = wdata;
      cpu.ram_flag  = flag;
      err_clr       = clr;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; abort_lo = 0;
      rst_n = 1'b0; err_clr = 1'b0;
      cpu.ram_cen = 1'b0; cpu.ram_wen = 1'b0; cpu.ram_addr = '0;
      cpu.ram_wdata = '0; cpu.ram_flag = '0;
      slv.slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_0001};
      repeat (2) @(posedge clk);
      #3;
      chk("rst_abort", {31'h0, cpu.ram_abort}, 32'h0);
      chk("rst_vld", {31'h0, err_vld}, 32'h0);
      chk("rst_addr", err_addr, 32'h0);
      chk("rst_cnt", {24'h0, err_cnt}, 32'h0);
      chk("rst_rdata", cpu.ram_rdata, 32'hA5A5_0001);
      rst_n = 1'b1;

      // mapped read, slave0
      drive(1'b1, 1'b0, 32'h4000_0010, 32'h0, 4'hF, 1'b0);
      chk("rd0_ce", {28'h0, slv.slv_ce}, 32'h1);
      chk("rd0_we", {31'h0, slv.slv_we}, 32'h0);
      chk("rd0_addr", slv.slv_addr, 32'h4000_0010);
      idle();
      chk("rd0_rdata", cpu.ram_rdata, 32'hA5A5_0001);
      chk("rd0_abort", {31'h0, cpu.ram_abort}, 32'h0);

      // mapped write, slave2
      drive(1'b1, 1'b1, 32'he000_0004, 32'h41, 4'h1, 1'b0);
      chk("wr2_ce", {28'h0, slv.slv_ce}, 32'h4);
      chk("wr2_we", {31'h0, slv.slv_we}, 32'h1);
      chk("wr2_wdata", slv.slv_wdata, 32'h41);
      chk("wr2_flag", {28'h0, slv.slv_flag}, 32'h1);
      idle();
      chk("wr2_abort", {31'h0, cpu.ram_abort}, 32'h0);
      chk("wr2_sel", cpu.ram_rdata, 32'h2222_2222);

      // slave3 then slave1 back to back
      drive(1'b1, 1'b0, 32'hd123_0000, 32'h0, 4'hF, 1'b0);
      chk("rd3_ce", {28'h0, slv.slv_ce}, 32'h8);
      drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
      chk("rd3_rdata", cpu.ram_rdata, 32'h3333_3333);
      chk("rd1_ce", {28'h0, slv.slv_ce}, 32'h2);
      idle();
      chk("rd1_rdata", cpu.ram_rdata, 32'h1111_1111);

      // unmapped read
      drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0);
      chk("um_ce", {28'h0, slv.slv_ce}, 32'h0);
      chk("um_abort_early", {31'h0, cpu.ram_abort}, 32'h0);
      idle();
      chk("um_abort", {31'h0, cpu.ram_abort}, 32'h1);
      chk("um_rdata", cpu.ram_rdata, 32'h0);
      chk("um_eaddr", err_addr, 32'h8000_0000);
      chk("um_ecnt", {24'h0, err_cnt}, 32'h1);
      chk("um_evld", {31'h0, err_vld}, 32'h1);
      idle();
      chk("um_abort_1cyc", {31'h0, cpu.ram_abort}, 32'h0);
      chk("um_rdata_hold", cpu.ram_rdata, 32'h0);

      // unmapped write: no strobe, address not recaptured
      drive(1'b1, 1'b1, 32'ha000_0000, 32'h55, 4'hF, 1'b0);
      chk("umw_we", {31'h0, slv.slv_we}, 32'h0);
      idle();
      chk("umw_eaddr", err_addr, 32'h8000_0000);
      chk("umw_ecnt", {24'h0, err_cnt}, 32'h2);

      // clear alone
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      idle();
      chk("clr_vld", {31'h0, err_vld}, 32'h0);
      chk("clr_cnt", {24'h0, err_cnt}, 32'h0);

      // 300 consecutive unmapped accesses
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 1'b0, 32'hb000_0000 + 32'(4 * k), 32'h0, 4'hF, 1'b0);
         if (k > 0 && cpu.ram_abort !== 1'b1) abort_lo++;
      end
      idle();
      if (cpu.ram_abort !== 1'b1) abort_lo++;
      chk("sat_abort_lo", abort_lo, 0);
      chk("sat_cnt", {24'h0, err_cnt}, 32'hFF);
      chk("sat_eaddr", err_addr, 32'hb000_0000);

      // clear with simultaneous unmapped access
      drive(1'b1, 1'b0, 32'h9000_0004, 32'h0, 4'hF, 1'b1);
      idle();
      chk("clrum_cnt", {24'h0, err_cnt}, 32'h1);
      chk("clrum_eaddr", err_addr, 32'h9000_0004);
      chk("clrum_vld", {31'h0, err_vld}, 32'h1);

      // reset cuts an unmapped access mid-cycle
      drive(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0);
      drive(1'b1, 1'b0, 32'he000_0000, 32'h0, 4'hF, 1'b0);
      drive(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'hF, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      cpu.ram_cen = 1'b0;
      #2;
      chk("mrst_abort", {31'h0, cpu.ram_abort}, 32'h0);
      chk("mrst_vld", {31'h0, err_vld}, 32'h0);
      chk("mrst_addr", err_addr, 32'h0);
      chk("mrst_cnt", {24'h0, err_cnt}, 32'h0);
      chk("mrst_rdata", cpu.ram_rdata, 32'hA5A5_0001);
      rst_n = 1'b1;
      idle();
      chk("mrst_abort2", {31'h0, cpu.ram_abort}, 32'h0);
      drive(1'b1, 1'b0, 32'hd000_0008, 32'h0, 4'hF, 1'b0);
      idle();
      chk("mrst_rd3", cpu.ram_rdata, 32'h3333_3333);
      chk("mrst_noabort", {31'h0, cpu.ram_abort}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
